multibyte_counter: RTL and testbench
====================================

// Module: multibyte_counter
// PURPOSE
// - Parametrised successor to the 8-bit loadable counter / 16-bit PC register:
//   NUM_BYTES lanes of DATA_WIDTH bits acting as one W=DATA_WIDTH*NUM_BYTES up/down counter.
// - Loaded and read byte-wise over the shared tri-state data bus through a lane select.
// - Drives the full count onto the address bus. Used as the PC, stack pointer or loop counter.
// PARAMETERS
// - DATA_WIDTH  `DATA_WIDTH  width of one bus byte lane
// - NUM_BYTES   2            number of lanes (>=1); W = DATA_WIDTH*NUM_BYTES
// - SEL_WIDTH   (NUM_BYTES>1 ? $clog2(NUM_BYTES) : 1)  lane-select width (localparam)
// PORTS
// - clk       in     1           single clock, rising edge
// - reset     in     1           synchronous, active-high
// - CS        in     1           chip select; gates WE, OE, CNT_EN, SYNC_CLR
// - WE        in     1           write selected lane from data
// - OE        in     1           drive selected lane onto data
// - SEL       in     SEL_WIDTH   lane select, 0 = least significant byte
// - CNT_EN    in     1           count enable
// - DIR       in     1           1 = up, 0 = down
// - SYNC_CLR  in     1           synchronous clear of whole count
// - OE_A      in     1           drive count onto address (independent of CS)
// - data      inout  DATA_WIDTH  shared system data bus
// - address   out    W           count when OE_A, else high-Z
// - count_out out    W           count, always driven
// - carry     out    1           terminal-count / ripple-out (combinational)
// - ovf       out    1           one-cycle pulse after a wrap or saturation event
// BEHAVIOUR
// - Reset (sync): count = 0 and ovf = 0. address is high-Z unless OE_A.
// - Per-edge priority:
//   reset > CS&SYNC_CLR (count=0) > CS&WE (load lane) > CS&CNT_EN (count) > hold.
// - Load: lane SEL <= data at the edge; other lanes hold. No count occurs in a load cycle.
// - SEL >= NUM_BYTES: the write is ignored and a read drives all zeros.
// - Count: up => count+1, down => count-1, modulo 2^W.
//   Carry/borrow ripples across all lanes in the same cycle.
// - carry = CS & CNT_EN & (DIR ? count==all-ones : count==0). Evaluated even during WE/SYNC_CLR.
// - ovf <= 1 on the edge after an actual count step taken while carry=1, else 0.
//   It is registered and lasts exactly one cycle.
// - Read: data = lane SEL when CS & OE & ~WE, else high-Z. WE&OE together: no drive.
//   Readback is the pre-edge value, so a same-cycle load or count shows next cycle.
// - address = count when OE_A else high-Z. count_out is unaffected by OE_A.
// - Reset mid-count or mid-load: reset wins, and the lane write is lost.
// - DIR may change on any cycle; only its value at the edge matters.
// CONFIGURATION
// - Macro MULTIBYTE_COUNTER_SATURATE_EN:
//   - Defined: at the terminal value, a count step holds (all-ones up / zero down) instead of wrapping.
//     carry and ovf behave identically to the undefined case.
//   - Undefined: modulo-2^W wrap-around as above.
// TESTING (DATA_WIDTH=8, NUM_BYTES=2 unless noted)
// - Reset, then write SEL=0 data=0x12 and SEL=1 data=0x34
//   -> count_out=0x3412. OE reads back 0x12 and 0x34. data is Z when OE=0 or CS=0.
// - Load 0x00FF, CNT_EN=1 DIR=1 for 1 clk -> 0x0100, carry=0.
//   Then DIR=0 for 2 clks -> 0x00FE.
// - Load 0xFFFF, DIR=1 CNT_EN=1 -> carry=1 before edge. Then 0x0000 (0xFFFF if SATURATE_EN).
//   ovf=1 for one cycle. Repeat down from 0x0000.
// - Count=0x0010 with WE=1 SEL=0 data=0xAA and CNT_EN=1 in the same cycle
//   -> 0x00AA, no increment, ovf=0.
// - SYNC_CLR=1 with WE=1 -> 0x0000. Same with CS=0 -> count holds.
//   reset=1 with CNT_EN=1 -> 0x0000, ovf=0.
// - OE_A toggles -> address = count_out / high-Z.
//   NUM_BYTES=3: SEL=3 write ignored, read returns 0x00.
//   Count 0x00FFFF -> 0x010000.

Source files
------------

// File: rtl/multibyte_counter.sv
// multibyte_counter: NUM_BYTES lanes of DATA_WIDTH bits forming one up/down
// counter of W = DATA_WIDTH*NUM_BYTES bits. It is loaded and read byte-wise over
// a shared tri-state data bus, drives its full count onto a tri-state address
// bus, and flags terminal count (carry) and wrap/saturation events (ovf).
// Optional feature macro: MULTIBYTE_COUNTER_SATURATE_EN. When it is defined,
// the count holds at its terminal value instead of wrapping.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module multibyte_counter #(
  parameter  int DATA_WIDTH = `DATA_WIDTH,
  parameter  int NUM_BYTES  = 2,
  localparam int W          = DATA_WIDTH * NUM_BYTES,
  localparam int SEL_WIDTH  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  CS,
  input  logic                  WE,
  input  logic                  OE,
  input  logic [SEL_WIDTH-1:0]  SEL,
  input  logic                  CNT_EN,
  input  logic                  DIR,
  input  logic                  SYNC_CLR,
  input  logic                  OE_A,
  inout  wire  [DATA_WIDTH-1:0] data,
  output wire  [W-1:0]          address,
  output logic [W-1:0]          count_out,
  output logic                  carry,
  output logic                  ovf
);

  logic [W-1:0]          r_count;
  logic                  r_ovf;

  logic [W-1:0]          w_count_nxt;
  logic [W-1:0]          w_count_inc;
  logic [W-1:0]          w_count_dec;
  logic                  w_at_term;
  logic                  w_sat_hold;
  logic                  w_step;
  logic                  w_ovf_nxt;
  logic                  w_rd_en;
  logic [DATA_WIDTH-1:0] w_rd_lane;

  // The whole W-bit value counts as one word, so the carry or borrow passes
  // through every lane in the same cycle.
  assign w_count_inc = r_count + {{(W-1){1'b0}}, 1'b1};
  assign w_count_dec = r_count - {{(W-1){1'b0}}, 1'b1};

  // Terminal value depends on the direction sampled this cycle.
  assign w_at_term = DIR ? (r_count == {W{1'b1}}) : (r_count == {W{1'b0}});

  // carry is evaluated even when a clear or a load takes priority this cycle.
  assign carry = CS & CNT_EN & w_at_term;

`ifdef MULTIBYTE_COUNTER_SATURATE_EN
  // At the terminal value, a count step holds the count instead of wrapping.
  assign w_sat_hold = w_at_term;
`else
  assign w_sat_hold = 1'b0;
`endif

  // Choose the next count in priority order: clear, lane load, count step, hold.
  always_comb begin
    w_count_nxt = r_count;
    w_step      = 1'b0;
    if (CS && SYNC_CLR) begin
      w_count_nxt = {W{1'b0}};
    end else if (CS && WE) begin
      // A select beyond the last lane matches no lane, so the write is dropped.
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (SEL == SEL_WIDTH'(i)) begin
          w_count_nxt[i*DATA_WIDTH +: DATA_WIDTH] = data;
        end else begin
          w_count_nxt[i*DATA_WIDTH +: DATA_WIDTH] = r_count[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end else if (CS && CNT_EN) begin
      w_step = 1'b1;
      if (w_sat_hold) begin
        w_count_nxt = r_count;
      end else if (DIR) begin
        w_count_nxt = w_count_inc;
      end else begin
        w_count_nxt = w_count_dec;
      end
    end else begin
      w_count_nxt = r_count;
    end
  end

  // ovf is raised only when a count step is taken from the terminal value.
  // This covers both a wrap and a saturation hold.
  assign w_ovf_nxt = w_step & w_at_term;

  // Count and overflow registers with a synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= {W{1'b0}};
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Read mux: choose the lane given by SEL. A select beyond the last lane reads zero.
  always_comb begin
    w_rd_lane = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (SEL == SEL_WIDTH'(i)) begin
        w_rd_lane = r_count[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        w_rd_lane = w_rd_lane;
      end
    end
  end

  // The count is never driven while WE is high, so the driver of the write
  // data does not contend with the readback. Readback shows the pre-edge count.
  assign w_rd_en = CS & OE & ~WE;
  assign data    = w_rd_en ? w_rd_lane : {DATA_WIDTH{1'bz}};

  assign address   = OE_A ? r_count : {W{1'bz}};
  assign count_out = r_count;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_multibyte_counter.sv
// Scoreboard bench for multibyte_counter.
// Stimulus pushes the expected outputs computed by an arithmetic reference
// model. A negedge monitor pops each entry and compares it with the DUT outputs.
// A second instance with NUM_BYTES=3 covers the out-of-range select and the
// three-lane carry ripple.

module tb_multibyte_counter;

  localparam longint MODV = 64'd65536;
  localparam longint MAXV = 64'd65535;
`ifdef MULTIBYTE_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic       rst;
    logic       cs;
    logic       we;
    logic       oe;
    logic       cnt_en;
    logic       dir;
    logic       clr;
    logic       oe_a;
    logic [0:0] sel;
    logic [7:0] d;
  } in_t;

  typedef struct packed {
    logic [15:0] cnt;
    logic        ovf;
    logic        car;
    logic        chk_d;
    logic [7:0]  d;
    logic [15:0] addr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Two-lane DUT signals
  logic        reset, CS, WE, OE, CNT_EN, DIR, SYNC_CLR, OE_A;
  logic [0:0]  SEL;
  logic        tb_drv;
  logic [7:0]  tb_d;
  wire  [7:0]  data_w;
  wire  [15:0] addr_w;
  logic [15:0] count_out;
  logic        carry, ovf;

  assign data_w = tb_drv ? tb_d : 8'hzz;
  pullup (data_w);
  pullup (addr_w);

  multibyte_counter #(.DATA_WIDTH(8), .NUM_BYTES(2)) u_dut (
    .clk(clk), .reset(reset), .CS(CS), .WE(WE), .OE(OE), .SEL(SEL),
    .CNT_EN(CNT_EN), .DIR(DIR), .SYNC_CLR(SYNC_CLR), .OE_A(OE_A),
    .data(data_w), .address(addr_w), .count_out(count_out),
    .carry(carry), .ovf(ovf)
  );

  // Three-lane DUT signals
  logic        r3, cs3, we3, oe3, en3, dir3, clr3, oea3;
  logic [1:0]  sel3;
  logic        drv3;
  logic [7:0]  d3;
  wire  [7:0]  data3_w;
  wire  [23:0] addr3_w;
  logic [23:0] count3;
  logic        carry3, ovf3;

  assign data3_w = drv3 ? d3 : 8'hzz;
  pullup (data3_w);

  multibyte_counter #(.DATA_WIDTH(8), .NUM_BYTES(3)) u_dut3 (
    .clk(clk), .reset(r3), .CS(cs3), .WE(we3), .OE(oe3), .SEL(sel3),
    .CNT_EN(en3), .DIR(dir3), .SYNC_CLR(clr3), .OE_A(oea3),
    .data(data3_w), .address(addr3_w), .count_out(count3),
    .carry(carry3), .ovf(ovf3)
  );

  int     n_checks = 0;
  int     n_err    = 0;
  exp_t   q[$];
  longint m_cnt;
  bit     m_ovf;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_checks++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic in_t base();
    in_t s;
    s = '0;
    s.cs = 1'b1;
    return s;
  endfunction

  // Apply one cycle of stimulus, push the expected outputs, then advance the model.
  task automatic cyc(input in_t s);
    exp_t   e;
    bit     car;
    longint sh;
    @(posedge clk);
    #1;
    reset = s.rst; CS = s.cs; WE = s.we; OE = s.oe; CNT_EN = s.cnt_en;
    DIR = s.dir; SYNC_CLR = s.clr; OE_A = s.oe_a; SEL = s.sel;
    tb_drv = s.we; tb_d = s.d;

    sh  = longint'(1) << (8 * int'(s.sel));
    car = s.cs && s.cnt_en && (s.dir ? (m_cnt == MAXV) : (m_cnt == 0));
    e.cnt   = 16'(m_cnt);
    e.ovf   = m_ovf;
    e.car   = car;
    e.chk_d = !s.we;
    e.d     = (s.cs && s.oe) ? 8'((m_cnt / sh) % 256) : 8'hFF;
    e.addr  = s.oe_a ? 16'(m_cnt) : 16'hFFFF;
    q.push_back(e);

    if (s.rst) begin
      m_cnt = 0;
      m_ovf = 1'b0;
    end else begin
      m_ovf = s.cs && !s.clr && !s.we && s.cnt_en && car;
      if (s.cs && s.clr) begin
        m_cnt = 0;
      end else if (s.cs && s.we) begin
        m_cnt = m_cnt - ((m_cnt / sh) % 256) * sh + longint'(s.d) * sh;
      end else if (s.cs && s.cnt_en) begin
        if (s.dir) m_cnt = (SAT && m_cnt == MAXV) ? m_cnt : (m_cnt + 1) % MODV;
        else       m_cnt = (SAT && m_cnt == 0)    ? m_cnt : (m_cnt + MODV - 1) % MODV;
      end
    end
  endtask

  task automatic load16(input logic [15:0] v);
    in_t s;
    s = base(); s.we = 1'b1; s.sel = 1'b0; s.d = v[7:0];  cyc(s);
    s = base(); s.we = 1'b1; s.sel = 1'b1; s.d = v[15:8]; cyc(s);
  endtask

  task automatic step(input logic dir);
    in_t s;
    s = base(); s.cnt_en = 1'b1; s.dir = dir; cyc(s);
  endtask

  task automatic idle();
    cyc(base());
  endtask

  // Monitor: compare each expected entry with the DUT outputs at mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("count_out", count_out, e.cnt);
      chk("ovf", ovf, e.ovf);
      chk("carry", carry, e.car);
      chk("address", addr_w, e.addr);
      if (e.chk_d) chk("data", data_w, e.d);
    end
  end

  initial begin
    in_t s;
    int  r;
    reset = 1'b1; CS = 1'b0; WE = 1'b0; OE = 1'b0; CNT_EN = 1'b0; DIR = 1'b0;
    SYNC_CLR = 1'b0; OE_A = 1'b0; SEL = 1'b0; tb_drv = 1'b0; tb_d = 8'h00;
    r3 = 1'b1; cs3 = 1'b0; we3 = 1'b0; oe3 = 1'b0; en3 = 1'b0; dir3 = 1'b0;
    clr3 = 1'b0; oea3 = 1'b0; sel3 = 2'd0; drv3 = 1'b0; d3 = 8'h00;
    m_cnt = 0; m_ovf = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state
    idle();
    @(negedge clk);
    chk("reset_count", count_out, 64'h0);
    chk("reset_ovf", ovf, 64'h0);

    // Byte load and readback, plus the bus left undriven when not read
    load16(16'h3412);
    idle();
    @(negedge clk);
    chk("load_3412", count_out, 64'h3412);
    s = base(); s.oe = 1'b1; s.sel = 1'b0; cyc(s);
    s = base(); s.oe = 1'b1; s.sel = 1'b1; cyc(s);
    s = base(); s.oe = 1'b0; cyc(s);
    s = base(); s.cs = 1'b0; s.oe = 1'b1; cyc(s);
    s = base(); s.oe = 1'b1; s.we = 1'b1; s.sel = 1'b0; s.d = 8'h12; cyc(s);

    // Carry ripples across lanes, then count down twice
    load16(16'h00FF);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    idle();
    @(negedge clk);
    chk("updown_00FE", count_out, 64'h00FE);

    // Terminal count going up, then going down
    load16(16'hFFFF);
    step(1'b1);
    idle();
    @(negedge clk);
    chk("wrap_up_ovf", ovf, 64'h1);
    chk("wrap_up_cnt", count_out, SAT ? 64'hFFFF : 64'h0);
    idle();
    load16(16'h0000);
    step(1'b0);
    idle();
    @(negedge clk);
    chk("wrap_dn_cnt", count_out, SAT ? 64'h0 : 64'hFFFF);
    idle();

    // A load in the same cycle as CNT_EN wins, so no count step occurs
    load16(16'h0010);
    s = base(); s.we = 1'b1; s.sel = 1'b0; s.d = 8'hAA; s.cnt_en = 1'b1; s.dir = 1'b1; cyc(s);
    idle();
    @(negedge clk);
    chk("load_beats_cnt", count_out, 64'h00AA);

    // Clear over load, clear blocked by CS, reset over count
    s = base(); s.clr = 1'b1; s.we = 1'b1; s.d = 8'h77; cyc(s);
    load16(16'h1234);
    s = base(); s.cs = 1'b0; s.clr = 1'b1; cyc(s);
    load16(16'hFFFF);
    s = base(); s.rst = 1'b1; s.cnt_en = 1'b1; s.dir = 1'b1; cyc(s);
    idle();
    @(negedge clk);
    chk("reset_beats_cnt", count_out, 64'h0);

    // Address enable toggling
    load16(16'h5A3C);
    s = base(); s.oe_a = 1'b1; cyc(s);
    s = base(); s.oe_a = 1'b0; cyc(s);
    s = base(); s.oe_a = 1'b1; s.cnt_en = 1'b1; s.dir = 1'b1; cyc(s);

    // Random stimulus; 0x00/0xFF lane data makes the terminal values reachable
    for (int k = 0; k < 800; k++) begin
      s.rst    = ($urandom_range(0, 59) == 0);
      s.cs     = ($urandom_range(0, 7) != 0);
      s.we     = ($urandom_range(0, 4) == 0);
      s.oe     = ($urandom_range(0, 1) == 0);
      s.cnt_en = ($urandom_range(0, 1) == 0);
      s.dir    = ($urandom_range(0, 1) == 0);
      s.clr    = ($urandom_range(0, 29) == 0);
      s.oe_a   = ($urandom_range(0, 1) == 0);
      s.sel    = 1'($urandom_range(0, 1));
      r        = int'($urandom_range(0, 5));
      s.d      = (r < 2) ? 8'hFF : (r < 4) ? 8'h00 : 8'($urandom);
      cyc(s);
    end

    // Let the monitor empty the queue, with a bounded wait
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 64'h0);

    // Three-lane instance: ignored write with SEL=3 and carry into the top lane
    @(posedge clk); #1;
    r3 = 1'b0; cs3 = 1'b1; we3 = 1'b1; drv3 = 1'b1; sel3 = 2'd0; d3 = 8'hFF;
    @(posedge clk); #1; sel3 = 2'd1; d3 = 8'hFF;
    @(posedge clk); #1; sel3 = 2'd2; d3 = 8'h00;
    @(posedge clk); #1; sel3 = 2'd3; d3 = 8'h55;
    @(posedge clk); #1; we3 = 1'b0; drv3 = 1'b0; oe3 = 1'b1; sel3 = 2'd3;
    @(negedge clk);
    chk("nb3_sel3_read", data3_w, 64'h00);
    chk("nb3_sel3_wr_ignored", count3, 64'h00FFFF);
    @(posedge clk); #1; oe3 = 1'b0; en3 = 1'b1; dir3 = 1'b1;
    @(posedge clk); #1; en3 = 1'b0;
    @(negedge clk);
    chk("nb3_ripple", count3, 64'h010000);
    chk("nb3_ovf", ovf3, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
